rr_arb_mux_4b_5to1: RTL
=======================

RR_ARB_MUX_4B_5TO1 -- requirements
Module: rr_arb_mux_4b_5to1

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports in0..in4, input, 4 bits each: requester data.
REQ-004 SHALL have port in_val, input, 5 bits: bit i means requester i holds valid data.
REQ-005 SHALL have port in_rdy, output, 5 bits: bit i means requester i's data is accepted this cycle.
REQ-006 SHALL have port out, output, 4 bits: registered selected data.
REQ-007 SHALL have port out_val, output, 1 bit: out holds valid data.
REQ-008 SHALL have port out_rdy, input, 1 bit: downstream accepts out this cycle.
REQ-009 SHALL have port sel, output, 3 bits: index (0-4) of the requester that supplied out.

Function
REQ-010 SHALL transfer input i when in_val[i] && in_rdy[i] in the same cycle; transfer out when out_val && out_rdy.
REQ-011 SHALL compute accept = !out_val || out_rdy (one-entry pipeline buffer; full-throughput pass-through).
REQ-012 SHALL compute the grant combinationally: first i with in_val[i] set, scanning from ptr upward modulo 5 (ptr, ptr+1, ..., 4, 0, ...).
REQ-013 SHALL assert in_rdy[g] only for granted index g, only when accept=1; all other in_rdy bits SHALL be 0; in_rdy SHALL be 5'b0 when in_val=0.
REQ-014 SHALL NOT let in_rdy depend on in_val of the same index except through the grant (no combinational path from out_rdy to out).
REQ-015 On an input transfer, SHALL load out<=in_g, sel<=g, out_val<=1 at the next rising edge (latency 1 cycle).
REQ-016 On an output transfer with no input transfer, SHALL clear out_val; out and sel SHALL hold their values.
REQ-017 With out_val=1 and out_rdy=0, SHALL hold out, sel, out_val, and ptr unchanged.
REQ-018 After each input transfer from g, ptr SHALL become (g+1) mod 5; g=4 wraps to ptr=0.
REQ-019 ptr SHALL be 3 bits, legal values 0-4; values 5-7 are unreachable and SHALL be treated as 0.
REQ-020 State SHALL be out_val: EMPTY (0) -> FULL on input transfer; FULL -> EMPTY on output transfer without input transfer; FULL -> FULL on simultaneous output and input transfer (new data replaces old in the same edge).
REQ-021 Fairness: with all five in_val held high and out_rdy=1, grants SHALL cycle 0,1,2,3,4,0,...

Reset
REQ-022 While reset_n=0, SHALL force out_val=0, out=4'b0, sel=3'd0, ptr=0, independent of clk.
REQ-023 While reset_n=0, in_rdy SHALL be 5'b0; any in-flight out data SHALL be discarded.
REQ-024 The first grant after reset deassertion SHALL favour requester 0.

Structure
REQ-025 A shared package SHALL define NUM_REQ=5, DATA_W=4, and typedef sel_t (3-bit index).
REQ-026 The priority-scan logic SHALL be a sub-module rr_arb_5 (inputs: in_val, ptr; outputs: one-hot grant, grant index, any_grant). The data mux and output register SHALL be inline.

Verification
REQ-027 Reset, then in_val=5'b00100, in2=4'hA, out_rdy=1 -> in_rdy=5'b00100; next cycle out=4'hA, sel=2, out_val=1; ptr=3.
REQ-028 All in_val=1, inI=I+1, out_rdy=1 for 6 cycles -> out sequence 1,2,3,4,5,1; sel 0,1,2,3,4,0 (wrap-around).
REQ-029 out_val=1, out_rdy=0, in_val=5'b11111 -> in_rdy=0; out/sel/ptr stable for 3 cycles; then out_rdy=1 -> transfer occurs and new data appears the next cycle.
REQ-030 ptr=3, in_val=5'b00101 -> grant 0 (scan 3,4,0); ptr becomes 1; next grant with same in_val is 2.
REQ-031 Assert reset_n=0 mid-cycle while out_val=1 -> out_val=0, out=0, sel=0 immediately, with no clk edge required; after release, in_val=5'b10001 -> grant 0.
REQ-032 out_val=1, out_rdy=1, in_val[1]=1 with in1=4'h7 -> both transfers occur in the same cycle; next cycle out_val=1, out=4'h7, sel=1.

Source files
------------

// File: rtl/rr_arb_mux_4b_5to1_pkg.sv
// Shared sizes, index type and modulo helper for the 5-way round-robin arbiter/mux.
package rr_arb_mux_4b_5to1_pkg;

  localparam int NUM_REQ = 5;
  localparam int DATA_W  = 4;

  typedef logic [2:0] sel_t;

  // Modulo-NUM_REQ add; both operands are expected in 0..NUM_REQ-1.
  function automatic sel_t wrap_add(input sel_t a, input sel_t b);
    logic [3:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 4'(NUM_REQ)) begin
      sum = sum - 4'(NUM_REQ);
    end
    return sum[2:0];
  endfunction

endpackage

// File: rtl/rr_arb_5.sv
// Round-robin priority scan over five requesters, starting at ptr and wrapping.
module rr_arb_5
  import rr_arb_mux_4b_5to1_pkg::*;
(
  input  logic [NUM_REQ-1:0] in_val,
  input  sel_t               ptr,
  output logic [NUM_REQ-1:0] grant,
  output sel_t               grant_idx,
  output logic               any_grant
);

  sel_t               ptr_eff;
  sel_t               cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_val;

  // Unreachable pointer codes fall back to requester 0.
  assign ptr_eff = (ptr >= sel_t'(NUM_REQ)) ? sel_t'(0) : ptr;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = wrap_add(ptr_eff, sel_t'(gi));
      assign cand_val[gi] = in_val[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_val[k]) begin
        grant_idx = cand_idx[k];
        any_grant = 1'b1;
      end
    end
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb_mux_4b_5to1.sv
// Five-input round-robin arbiter feeding a one-entry registered output buffer.
module rr_arb_mux_4b_5to1
  import rr_arb_mux_4b_5to1_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  in1,
  input  logic [DATA_W-1:0]  in2,
  input  logic [DATA_W-1:0]  in3,
  input  logic [DATA_W-1:0]  in4,
  input  logic [NUM_REQ-1:0] in_val,
  output logic [NUM_REQ-1:0] in_rdy,
  output logic [DATA_W-1:0]  out,
  output logic               out_val,
  input  logic               out_rdy,
  output sel_t               sel
);

  logic [NUM_REQ-1:0][DATA_W-1:0] in_bus;
  logic [NUM_REQ-1:0]             grant;
  sel_t                           grant_idx;
  logic                           any_grant;
  logic                           accept;
  logic                           in_xfer;
  logic [DATA_W-1:0]              mux_data;

  logic [DATA_W-1:0] out_reg;
  logic              out_val_reg;
  sel_t              sel_reg;
  sel_t              ptr_reg;

  assign in_bus = {in4, in3, in2, in1, in0};

  rr_arb_5 u_arb (
    .in_val    (in_val),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Buffer can take new data when empty or when its current entry leaves this cycle.
  assign accept  = !out_val_reg || out_rdy;
  assign in_rdy  = (reset_n && accept) ? grant : '0;
  assign in_xfer = any_grant && accept;

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mux_data = mux_data | in_bus[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg     <= '0;
      out_val_reg <= 1'b0;
      sel_reg     <= '0;
      ptr_reg     <= '0;
    end else if (in_xfer) begin
      out_reg     <= mux_data;
      sel_reg     <= grant_idx;
      out_val_reg <= 1'b1;
      ptr_reg     <= wrap_add(grant_idx, sel_t'(1));
    end else if (out_val_reg && out_rdy) begin
      out_val_reg <= 1'b0;
    end
  end

  assign out     = out_reg;
  assign out_val = out_val_reg;
  assign sel     = sel_reg;

endmodule
